// File: rtl/swipt_link_tx_if.sv
// Frequency-request channel of the SWIPT carrier transmitter.
// The requester drives f_req/f_valid and must hold them until f_ready is seen.
`timescale 1ns/1ps
interface swipt_link_tx_if;
    logic [31:0] f_req;
    logic        f_valid;
    logic        f_ready;

    modport master (output f_req, output f_valid, input f_ready);
    modport slave  (input f_req, input f_valid, output f_ready);
endinterface

// File: rtl/swipt_link_tx.sv
// SWIPT link carrier generator: a square wave whose frequency is set in Hz.
// A 32-step restoring divider turns each request into a half-period count, which is applied on a rising carrier edge.
`timescale 1ns/1ps
module swipt_link_tx #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned F_DEFAULT = 40000,
    parameter int unsigned F_MIN     = 20000,
    parameter int unsigned F_MAX     = 80000,
    parameter int unsigned SETTLE    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    swipt_link_tx_if.slave        req,
    output logic                  o_link,
    output logic [31:0]           o_f_cur,
    output logic                  o_freq_rdy
);

    localparam logic [31:0] HALF_RST = 32'(CLK_HZ / (2 * F_DEFAULT));
    localparam logic [31:0] DIVIDEND = 32'(CLK_HZ / 2);
    localparam logic [31:0] F_MIN_V  = 32'(F_MIN);
    localparam logic [31:0] F_MAX_V  = 32'(F_MAX);
    localparam logic [31:0] F_DEF_V  = 32'(F_DEFAULT);
    localparam int          SW       = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
    localparam logic [SW-1:0] ONE_S    = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    function automatic logic [31:0] clamp_f(input logic [31:0] f);
        if (f < F_MIN_V) begin
            clamp_f = F_MIN_V;
        end else if (f > F_MAX_V) begin
            clamp_f = F_MAX_V;
        end else begin
            clamp_f = f;
        end
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_apply;
    logic            w_rise;

    logic [31:0]     r_div;
    logic [31:0]     r_quo;
    logic [31:0]     r_rem;
    logic [5:0]      r_step;
    logic [31:0]     r_pend_half;
    logic [31:0]     r_pend_f;
    logic [32:0]     w_rem_sh;
    logic            w_ge;
    logic [31:0]     w_rem_nxt;

    logic [31:0]     r_cnt;
    logic [31:0]     r_half;
    logic [31:0]     r_f_cur;
    logic            r_link;
    logic [SW-1:0]   r_settle;

    assign w_rise    = i_en && (r_cnt == 32'd0) && !r_link;
    assign w_rem_sh  = {r_rem, r_quo[31]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? 32'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[31:0];

    assign req.f_ready = (r_state == S_IDLE);
    assign o_link      = r_link;
    assign o_f_cur     = r_f_cur;
    assign o_freq_rdy  = (r_settle == SETTLE_V) && i_en;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; pending values apply on a rising toggle, or at once while disabled
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req.f_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_DIV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                if (r_step == 6'd32) begin
                    w_state_nxt = S_PEND;
                end else begin
                    w_state_nxt = S_DIV;
                end
            end
            S_PEND: begin
                if (!i_en || w_rise) begin
                    w_apply     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_PEND;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Restoring divider: quotient bits shift in from the bottom of r_quo
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div       <= F_DEF_V;
            r_quo       <= 32'd0;
            r_rem       <= 32'd0;
            r_step      <= 6'd0;
            r_pend_half <= HALF_RST;
            r_pend_f    <= F_DEF_V;
        end else if (w_accept) begin
            r_div  <= clamp_f(req.f_req);
            r_quo  <= DIVIDEND;
            r_rem  <= 32'd0;
            r_step <= 6'd0;
        end else if (r_state == S_DIV) begin
            if (r_step == 6'd32) begin
                r_pend_half <= r_quo;
                r_pend_f    <= r_div;
            end else begin
                r_rem  <= w_rem_nxt;
                r_quo  <= {r_quo[30:0], w_ge};
                r_step <= r_step + 6'd1;
            end
        end else begin
            r_step <= r_step;
        end
    end

    // Carrier counter, applied frequency and settle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_link   <= 1'b0;
            r_cnt    <= HALF_RST - 32'd1;
            r_half   <= HALF_RST;
            r_f_cur  <= F_DEF_V;
            r_settle <= '0;
        end else if (!i_en) begin
            r_link   <= 1'b0;
            r_settle <= '0;
            if (w_apply) begin
                r_half  <= r_pend_half;
                r_f_cur <= r_pend_f;
                r_cnt   <= r_pend_half - 32'd1;
            end else begin
                r_cnt <= r_half - 32'd1;
            end
        end else if (r_cnt == 32'd0) begin
            r_link <= ~r_link;
            if (w_apply) begin
                // New high phase already runs at the new half; the low phase just ended used the old one
                r_cnt    <= r_pend_half - 32'd1;
                r_half   <= r_pend_half;
                r_f_cur  <= r_pend_f;
                r_settle <= '0;
            end else begin
                r_cnt <= r_half - 32'd1;
                if (!r_link && (r_settle != SETTLE_V)) begin
                    r_settle <= r_settle + ONE_S;
                end else begin
                    r_settle <= r_settle;
                end
            end
        end else begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

endmodule

// File: tb/tb_swipt_link_tx.sv
// Directed bench for swipt_link_tx: phase lengths, request handshake, clamping, enable and reset behaviour.
`timescale 1ns/1ps
module tb_swipt_link_tx;

    logic        clk;
    logic        rst;
    logic        en;
    logic        link;
    logic [31:0] f_cur;
    logic        freq_rdy;
    int          total;
    int          bad;
    int          n;

    swipt_link_tx_if req_if ();

    swipt_link_tx dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .req        (req_if),
        .o_link     (link),
        .o_f_cur    (f_cur),
        .o_freq_rdy (freq_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ticks until link reaches lvl, bounded by max
    task automatic wait_link(input logic lvl, input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while ((link !== lvl) && (cnt < max));
    endtask

    task automatic wait_ready(input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while ((req_if.f_ready !== 1'b1) && (cnt < max));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        chk("rst_link", {31'd0, link}, 32'd0);
        chk("rst_fcur", f_cur, 32'd40000);
        chk("rst_ready", {31'd0, req_if.f_ready}, 32'd1);
        chk("rst_frdy", {31'd0, freq_rdy}, 32'd0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        req_if.f_req   = 32'd0;
        req_if.f_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_link", {31'd0, link}, 32'd0);
        chk("reset_fcur", f_cur, 32'd40000);
        chk("reset_ready", {31'd0, req_if.f_ready}, 32'd1);
        chk("reset_frdy", {31'd0, freq_rdy}, 32'd0);

        // enable: first rise after 1250 clocks, 2500-clock period
        en = 1'b1;
        wait_link(1'b1, 4000, n);
        chk("first_rise", n, 32'd1250);
        chk("frdy_rise1", {31'd0, freq_rdy}, 32'd0);
        wait_link(1'b0, 4000, n);
        chk("high_40k", n, 32'd1250);
        wait_link(1'b1, 4000, n);
        chk("low_40k", n, 32'd1250);
        chk("frdy_rise2", {31'd0, freq_rdy}, 32'd1);

        // request 50000 right after a rising edge
        req_if.f_req   = 32'd50000;
        req_if.f_valid = 1'b1;
        tick();
        req_if.f_valid = 1'b0;
        chk("busy_50k", {31'd0, req_if.f_ready}, 32'd0);
        chk("frdy_pend", {31'd0, freq_rdy}, 32'd1);
        chk("fcur_pend", f_cur, 32'd40000);
        wait_ready(6000, n);
        chk("apply_wait_50k", n, 32'd2499);
        chk("apply_link_50k", {31'd0, link}, 32'd1);
        chk("fcur_50k", f_cur, 32'd50000);
        chk("frdy_apply", {31'd0, freq_rdy}, 32'd0);
        wait_link(1'b0, 4000, n);
        chk("high_50k", n, 32'd1000);
        wait_link(1'b1, 4000, n);
        chk("low_50k", n, 32'd1000);
        chk("frdy_50k_1", {31'd0, freq_rdy}, 32'd0);
        wait_link(1'b0, 4000, n);
        wait_link(1'b1, 4000, n);
        chk("frdy_50k_2", {31'd0, freq_rdy}, 32'd1);

        // clamp low: 10000 -> 20000, half 2500
        req_if.f_req   = 32'd10000;
        req_if.f_valid = 1'b1;
        tick();
        req_if.f_valid = 1'b0;
        wait_ready(6000, n);
        chk("apply_wait_10k", n, 32'd1999);
        chk("fcur_clamp_lo", f_cur, 32'd20000);
        wait_link(1'b0, 6000, n);
        chk("high_clamp_lo", n, 32'd2500);
        wait_link(1'b1, 6000, n);
        chk("low_clamp_lo", n, 32'd2500);

        // clamp high: 100000 -> 80000, half 625
        req_if.f_req   = 32'd100000;
        req_if.f_valid = 1'b1;
        tick();
        req_if.f_valid = 1'b0;
        wait_ready(8000, n);
        chk("apply_wait_100k", n, 32'd4999);
        chk("fcur_clamp_hi", f_cur, 32'd80000);
        wait_link(1'b0, 4000, n);
        chk("high_clamp_hi", n, 32'd625);
        wait_link(1'b1, 4000, n);
        chk("low_clamp_hi", n, 32'd625);

        // back-pressure: 60000 held valid while the 50000 request is in flight
        req_if.f_req   = 32'd50000;
        req_if.f_valid = 1'b1;
        tick();
        req_if.f_valid = 1'b0;
        repeat (5) tick();
        chk("busy_div", {31'd0, req_if.f_ready}, 32'd0);
        req_if.f_req   = 32'd60000;
        req_if.f_valid = 1'b1;
        wait_ready(4000, n);
        chk("bp_wait", n, 32'd1244);
        chk("bp_first_fcur", f_cur, 32'd50000);
        tick();
        req_if.f_valid = 1'b0;
        chk("bp_accepted", {31'd0, req_if.f_ready}, 32'd0);
        wait_ready(4000, n);
        chk("apply_wait_60k", n, 32'd1999);
        chk("fcur_60k", f_cur, 32'd60000);
        wait_link(1'b0, 4000, n);
        chk("high_60k", n, 32'd833);
        wait_link(1'b1, 4000, n);
        chk("low_60k", n, 32'd833);

        // enable low while pending: 30000 (half 1666) applies at T+34
        en = 1'b0;
        tick();
        chk("dis_link", {31'd0, link}, 32'd0);
        chk("dis_frdy", {31'd0, freq_rdy}, 32'd0);
        req_if.f_req   = 32'd30000;
        req_if.f_valid = 1'b1;
        tick();
        req_if.f_valid = 1'b0;
        wait_ready(200, n);
        chk("dis_apply_wait", n, 32'd34);
        chk("dis_fcur", f_cur, 32'd30000);
        chk("dis_link_held", {31'd0, link}, 32'd0);
        en = 1'b1;
        wait_link(1'b1, 4000, n);
        chk("en_first_rise", n, 32'd1666);
        wait_link(1'b0, 4000, n);
        chk("high_30k", n, 32'd1666);

        // reset during DIV
        req_if.f_req   = 32'd70000;
        req_if.f_valid = 1'b1;
        tick();
        req_if.f_valid = 1'b0;
        repeat (10) tick();
        pulse_rst();
        wait_link(1'b1, 4000, n);
        chk("rst_div_rise", n, 32'd1250);
        chk("rst_div_fcur", f_cur, 32'd40000);

        // reset during PEND
        req_if.f_req   = 32'd70000;
        req_if.f_valid = 1'b1;
        tick();
        req_if.f_valid = 1'b0;
        repeat (40) tick();
        chk("pend_busy", {31'd0, req_if.f_ready}, 32'd0);
        pulse_rst();
        wait_link(1'b1, 4000, n);
        chk("rst_pend_rise", n, 32'd1250);
        wait_link(1'b0, 4000, n);
        chk("rst_pend_high", n, 32'd1250);
        wait_link(1'b1, 4000, n);
        chk("rst_pend_low", n, 32'd1250);
        chk("rst_pend_fcur", f_cur, 32'd40000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/swipt_link_tx.md
# swipt_link_tx

Transmitter end of the SWIPT link: generates the square-wave `link` carrier that the receiver-side PLL phase-locks to. The carrier frequency is programmed in Hz through a valid/ready request port. A multi-cycle sequential divider converts each request into a half-period clock count, and the new count is applied glitch-free on the carrier's next rising edge. The block flags a settled carrier with `freq_rdy`.

## Interface
- `CLK_HZ`, 100000000: system clock frequency in Hz.
- `F_DEFAULT`, 40000: carrier frequency in Hz after reset.
- `F_MIN`, 20000: lower clamp for requests, in Hz.
- `F_MAX`, 80000: upper clamp for requests, in Hz.
- `SETTLE`, 2: number of full carrier periods before `freq_rdy` asserts.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: carrier enable.
- `f_req`  in  32: requested frequency in Hz.
- `f_valid`  in  1: request valid.
- `f_ready`  out  1: block can accept a request.
- `link`  out  1: carrier output.
- `f_cur`  out  32: frequency currently applied, in Hz (after clamping).
- `freq_rdy`  out  1: carrier has been stable at `f_cur` for `SETTLE` periods.

## Operation
- **Half-period.** `half = floor(CLK_HZ / (2*f))`, 32-bit unsigned.
  - Reset value is `half = CLK_HZ/(2*F_DEFAULT)`, an elaboration constant (1250 with the defaults).
- **Carrier counter.** Counter `cnt` runs with `en=1`.
  - At `cnt==0`: `link` toggles and `cnt` reloads with `half-1`.
  - Otherwise `cnt` decrements.
  - Each phase of `link` therefore lasts exactly `half` clocks.
- **Enable low.** `en=0` forces `link=0` and `cnt=half-1`, and clears the settle counter.
- **Request handshake.** A request is accepted when `f_valid && f_ready` on a rising clock edge.
  - The accepted `f_req` is clamped to [F_MIN, F_MAX] and latched.
- **FSM states:**
  - IDLE (`f_ready=1`). On accept, go to DIV.
  - DIV. Restoring divide of `CLK_HZ/2` by the latched frequency, one quotient bit per cycle, exactly 32 cycles. Then go to PEND with `pend_half` and `pend_f` registered.
  - PEND. With `en=1`, the pending values apply in the cycle `link` toggles 0->1:
    - the new high phase uses `cnt = pend_half-1`;
    - `half <= pend_half` and `f_cur <= pend_f`;
    - the settle counter clears;
    - go to IDLE.
  - With `en=0` in PEND, the pending values apply on the next cycle, `cnt` reloads with `pend_half-1`, and the FSM goes to IDLE.
- **`f_ready`.** Asserted only in IDLE. Requests arriving while the block is busy are not accepted and must be held by the requester.
- **Settle counter.** With `en=1`, the settle counter counts rising toggles of `link` at the current `half` and saturates at `SETTLE`.
  - `freq_rdy = (settle == SETTLE) && en`.
- **Reset.** Asynchronous `rst` aborts any divide or pending value. Reset values:
  - `link=0`, `cnt=CLK_HZ/(2*F_DEFAULT)-1`, `half` = reset constant;
  - `f_cur=F_DEFAULT`, `f_ready=1`, `freq_rdy=0`;
  - FSM in IDLE, settle counter 0.

## Timing
- **Divide latency.** Request accepted at edge T. DIV occupies T+1..T+32, and PEND is entered with values valid at T+33.
- **Application.** Values apply at the first 0->1 toggle of `link` strictly after PEND is entered.
  - If that toggle falls in the same cycle PEND is entered, the values wait one full period.
- **Glitch-free.** A frequency change never shortens or extends the low phase in progress. The preceding low phase uses the old `half`.
- **First edge.** After `en` rises, the first 0->1 toggle of `link` occurs after `half` clocks.
- **`freq_rdy` timing:**
  - Rises in the cycle of the `SETTLE`-th rising toggle after an apply, or after `en` rises.
  - Falls in the same cycle as an apply or as `en` going low.
- **Back-to-back requests.** Minimum spacing is 34 cycles plus the wait for the next period boundary.

## Test plan
- **Reset and enable.** Reset, then `en=1`. Expect `link` rising at +1250 clocks, period 2500 clocks, `f_cur=40000`, and `freq_rdy` rising at the 2nd rising edge.
- **Request 50000.** Expect `f_ready` low for 33+ cycles. The new high phase starts exactly at a rising edge, and phases are 1000 clocks thereafter. `f_cur=50000`, and `freq_rdy` drops and then rises again after 2 periods.
- **Clamping.** Request 10000 and expect `half=2500`, `f_cur=20000`. Request 100000 and expect `half=625`, `f_cur=80000`.
- **Busy back-pressure.** Assert `f_valid` with 60000 during DIV. Expect no acceptance until `f_ready` returns, then 60000 applied with `half=833`.
- **Enable low while pending.** Request with `en=0`. Expect the value applied at T+34, `link` held 0, and the first rising edge `half` clocks after `en` rises.
- **Reset mid-operation.** Assert `rst` mid-DIV and mid-PEND. Expect immediate return to the reset values, with no later application of the aborted frequency.
